// File: rtl/udp_payload_reader_pkg.sv
// ---------------------------------------------------------------------------
// udp_payload_reader_pkg
//
// Shared definitions for the UDP payload reader:
//   - default receive RAM address width and UDP header length
//   - FSM state encoding (IDLE = 0, READ = 1, DRAIN = 2)
//   - skid buffer entry layout (payload byte + end-of-packet flag)
//   - payload length helper (17-bit subtraction so underflow is visible)
//
// Optional statistics counters in the top are enabled with the macro
// UDP_PAYLOAD_READER_STATS_EN.
// ---------------------------------------------------------------------------
package udp_payload_reader_pkg;

    localparam int DEF_RAM_AW      = 11;
    localparam int DEF_UDP_HDR_LEN = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } skid_entry_t;

    // Bit 16 of the result is set when the UDP length is shorter than the
    // header, i.e. the subtraction wrapped.
    function automatic logic [16:0] payload_len(input logic [15:0] udp_len,
                                                input logic [15:0] hdr_len);
        return {1'b0, udp_len} - {1'b0, hdr_len};
    endfunction

endpackage

// File: rtl/udp_payload_reader_if.sv
// ---------------------------------------------------------------------------
// udp_payload_reader_if
//
// Bundles the bus-level signals of the UDP payload reader:
//   udp_rec_data_valid / udp_rec_data_length : packet-complete notification
//   udp_rec_ram_read_addr / _en / _rdata     : receive RAM read port
//                                              (rdata valid 1 cycle after en)
//   m_data / m_valid / m_last / m_ready      : output byte stream
//
// Modports:
//   master : the reader (drives RAM address/strobe and the stream)
//   slave  : the environment (RAM + notification source + stream sink)
// ---------------------------------------------------------------------------
interface udp_payload_reader_if
    import udp_payload_reader_pkg::*;
#(
    parameter int RAM_AW = DEF_RAM_AW
) ();

    logic              udp_rec_data_valid;
    logic [15:0]       udp_rec_data_length;
    logic [RAM_AW-1:0] udp_rec_ram_read_addr;
    logic              udp_rec_ram_read_en;
    logic [7:0]        udp_rec_ram_rdata;
    logic [7:0]        m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    modport master (
        input  udp_rec_data_valid,
        input  udp_rec_data_length,
        output udp_rec_ram_read_addr,
        output udp_rec_ram_read_en,
        input  udp_rec_ram_rdata,
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        output udp_rec_data_valid,
        output udp_rec_data_length,
        input  udp_rec_ram_read_addr,
        input  udp_rec_ram_read_en,
        output udp_rec_ram_rdata,
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/udp_rd_skid.sv
// ---------------------------------------------------------------------------
// udp_rd_skid
//
// Two-entry byte+last buffer sitting behind the receive RAM read port.
// Every byte returned by the RAM is either handed straight to the sink
// (buffer empty and sink ready) or stored, so nothing is lost under
// back-pressure. When the buffer is empty the returning RAM byte is shown
// on the output in the same cycle, giving 1 byte/cycle with no extra latency.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   rd_issue_i       a RAM read is issued this cycle
//   rd_last_i        the issued read is the final payload byte
//   rdata_i          RAM read data (valid the cycle after rd_issue_i)
//   m_data_o/m_last_o/m_valid_o/m_ready_i   output stream
//   occupancy_o      bytes currently stored (0..2)
//   inflight_o       a read issued last cycle returns its data now
// ---------------------------------------------------------------------------
module udp_rd_skid
    import udp_payload_reader_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rd_issue_i,
    input  logic       rd_last_i,
    input  logic [7:0] rdata_i,
    output logic [7:0] m_data_o,
    output logic       m_last_o,
    output logic       m_valid_o,
    input  logic       m_ready_i,
    output logic [1:0] occupancy_o,
    output logic       inflight_o
);

    logic        inflight_q;
    logic        inflight_last_q;
    logic [1:0]  occ_q, occ_d;
    logic        rd_ptr_q, wr_ptr_q;
    skid_entry_t entry_q [2];
    skid_entry_t head;

    logic has_data;
    logic pop;
    logic bypass;
    logic push;
    logic buf_pop;

    assign head     = entry_q[rd_ptr_q];
    assign has_data = (occ_q != 2'd0);

    assign m_valid_o = has_data || inflight_q;

    // Stored bytes always go first; the RAM byte is shown only when the
    // buffer is empty. Outputs are forced to zero when nothing is valid.
    always_comb begin
        m_data_o = 8'h00;
        m_last_o = 1'b0;
        if (has_data) begin
            m_data_o = head.data;
            m_last_o = head.last;
        end else if (inflight_q) begin
            m_data_o = rdata_i;
            m_last_o = inflight_last_q;
        end
    end

    assign pop     = m_valid_o && m_ready_i;
    assign bypass  = !has_data && inflight_q && m_ready_i;
    assign push    = inflight_q && !bypass;
    assign buf_pop = pop && has_data;

    assign occ_d = occ_q + {1'b0, push} - {1'b0, buf_pop};

    assign occupancy_o = occ_q;
    assign inflight_o  = inflight_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            occ_q           <= 2'd0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            inflight_q      <= rd_issue_i;
            inflight_last_q <= rd_issue_i && rd_last_i;
            occ_q           <= occ_d;
            rd_ptr_q        <= rd_ptr_q ^ buf_pop;
            wr_ptr_q        <= wr_ptr_q ^ push;
            if (push) begin
                entry_q[wr_ptr_q] <= '{last: inflight_last_q, data: rdata_i};
            end
        end
    end

endmodule

// File: rtl/udp_payload_reader.sv
// ---------------------------------------------------------------------------
// udp_payload_reader
//
// Reads a received UDP payload out of the receive RAM and presents it as a
// valid/ready/last byte stream. A packet-complete pulse in IDLE latches the
// payload length (UDP length minus header, clamped to the RAM depth), then
// bytes 0..plen-1 are read one per cycle as buffer credit allows.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   bus        udp_payload_reader_if.master (notification, RAM port, stream)
//   busy       high from an accepted pulse until the last byte is consumed
//   len_err    one-cycle pulse when a packet was truncated to RAM depth
//   pkt_cnt    (UDP_PAYLOAD_READER_STATS_EN only) packets delivered, saturating
//   drop_cnt   (UDP_PAYLOAD_READER_STATS_EN only) pulses ignored while busy,
//              saturating
//
// Optional feature macro: UDP_PAYLOAD_READER_STATS_EN.
// RAM_AW must match the RAM_AW of the connected interface instance.
// ---------------------------------------------------------------------------
module udp_payload_reader
    import udp_payload_reader_pkg::*;
#(
    parameter int RAM_AW      = DEF_RAM_AW,
    parameter int UDP_HDR_LEN = DEF_UDP_HDR_LEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    udp_payload_reader_if.master bus,
    output logic                 busy,
    output logic                 len_err
`ifdef UDP_PAYLOAD_READER_STATS_EN
    ,
    output logic [15:0]          pkt_cnt,
    output logic [15:0]          drop_cnt
`endif
);

    localparam int DEPTH = 1 << RAM_AW;

    state_e            state_q, state_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [RAM_AW-1:0] last_addr_q, last_addr_d;
    logic              len_err_q, len_err_d;

    logic [16:0]       plen_full;
    logic              no_payload;
    logic              too_long;
    logic              rd_en;
    logic              rd_last;
    logic              pop;
    logic              last_pop;
    logic              credit;
    logic [1:0]        occ;
    logic              inflight;

    assign plen_full  = payload_len(bus.udp_rec_data_length, 16'(UDP_HDR_LEN));
    assign no_payload = plen_full[16] || (plen_full == 17'd0);
    assign too_long   = plen_full > 17'(DEPTH);

    assign pop      = bus.m_valid && bus.m_ready;
    assign last_pop = pop && bus.m_last;

    // At most two bytes may be stored or returning at once; a byte leaving
    // this cycle frees a slot for the read issued now.
    assign credit = ((occ + {1'b0, inflight}) < 2'd2) || pop;

    assign rd_last = rd_en && (addr_q == last_addr_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        len_err_d   = 1'b0;
        rd_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.udp_rec_data_valid && !no_payload) begin
                    addr_d  = '0;
                    state_d = ST_READ;
                    if (too_long) begin
                        last_addr_d = '1;
                        len_err_d   = 1'b1;
                    end else begin
                        last_addr_d = RAM_AW'(plen_full - 17'd1);
                    end
                end
            end
            ST_READ: begin
                if (credit) begin
                    rd_en = 1'b1;
                    if (addr_q == last_addr_q) begin
                        // Hold the address so it never wraps past the end.
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + RAM_AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (last_pop) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            len_err_q   <= len_err_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign len_err = len_err_q;

    assign bus.udp_rec_ram_read_addr = addr_q;
    assign bus.udp_rec_ram_read_en   = rd_en;

    udp_rd_skid u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_issue_i  (rd_en),
        .rd_last_i   (rd_last),
        .rdata_i     (bus.udp_rec_ram_rdata),
        .m_data_o    (bus.m_data),
        .m_last_o    (bus.m_last),
        .m_valid_o   (bus.m_valid),
        .m_ready_i   (bus.m_ready),
        .occupancy_o (occ),
        .inflight_o  (inflight)
    );

`ifdef UDP_PAYLOAD_READER_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] drop_cnt_q;
    logic        drop_evt;

    // A pulse is only ever accepted in IDLE; anything else is a lost packet,
    // including a pulse in the same cycle the last byte leaves.
    assign drop_evt = bus.udp_rec_data_valid && (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= 16'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            if (last_pop && (pkt_cnt_q != 16'hFFFF)) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if (drop_evt && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_udp_payload_reader.sv
// ---------------------------------------------------------------------------
// tb_udp_payload_reader
//
// Scoreboard bench for udp_payload_reader. Each accepted pulse pushes the
// expected payload bytes (taken from the bench's RAM image, length clamped
// to RAM depth) into a queue; a monitor pops and compares on every stream
// handshake and also checks hold-while-stalled and RAM address range.
// ---------------------------------------------------------------------------
module tb_udp_payload_reader;

    localparam int AW    = 11;
    localparam int DEPTH = 2048;
    localparam int HDR   = 8;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    logic busy;
    logic len_err;
`ifdef UDP_PAYLOAD_READER_STATS_EN
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;
`endif

    udp_payload_reader_if #(.RAM_AW(AW)) bus ();

    udp_payload_reader #(.RAM_AW(AW), .UDP_HDR_LEN(HDR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .len_err  (len_err)
`ifdef UDP_PAYLOAD_READER_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    exp_t       exp_q[$];
    logic [7:0] mem [DEPTH];
    int         n_vec = 0;
    int         n_err = 0;
    int         exp_pkt = 0;
    int         exp_drop = 0;
    int         rd_limit = 0;
    int         rd_cnt = 0;
    int         ready_mode = 0;
    int         ready_phase = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Receive RAM model: registered read, 1 cycle latency.
    always @(posedge clk) begin
        if (bus.udp_rec_ram_read_en)
            bus.udp_rec_ram_rdata <= mem[bus.udp_rec_ram_read_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    endtask

    // Sink ready pattern: 0 = always, 1 = 1,0,0 repeating, 2 = random.
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.m_ready = 1'b1;
                1: begin
                    bus.m_ready = (ready_phase == 0);
                    ready_phase = (ready_phase + 1) % 3;
                end
                default: bus.m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard consumer.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        exp_t       e;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(bus.m_valid), 1);
                    chk("stall_data", 32'(bus.m_data), 32'(prev_data));
                    chk("stall_last", 32'(bus.m_last), 32'(prev_last));
                end
                if (bus.udp_rec_ram_read_en) begin
                    rd_cnt++;
                    chk("rd_addr_range", 32'(int'(bus.udp_rec_ram_read_addr) < rd_limit), 1);
                end
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %02h expected no byte", bus.m_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", 32'(bus.m_data), 32'(e.data));
                        chk("last", 32'(bus.m_last), 32'(e.last));
                        if (e.last) exp_pkt++;
                    end
                end
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_data  = bus.m_data;
                prev_last  = bus.m_last;
            end
        end
    end

    // Issue one packet-complete pulse; the model accepts it only when no
    // packet is outstanding.
    task automatic send(input int len);
        bit drop;
        bit clamp;
        int plen;
        drop  = (exp_q.size() != 0);
        clamp = 1'b0;
        plen  = 0;
        bus.udp_rec_data_length = 16'(len);
        bus.udp_rec_data_valid  = 1'b1;
        if (drop) begin
            exp_drop++;
        end else if (len > HDR) begin
            plen = len - HDR;
            if (plen > DEPTH) begin
                plen  = DEPTH;
                clamp = 1'b1;
            end
            for (int i = 0; i < plen; i++)
                exp_q.push_back('{last: (i == plen - 1), data: mem[i]});
            rd_limit = plen;
        end
        $display("pulse len=%0d plen=%0d %s ready_mode=%0d", len, plen,
                 drop ? "dropped" : "accepted", ready_mode);
        @(posedge clk);
        #1;
        bus.udp_rec_data_valid = 1'b0;
        chk("len_err", 32'(len_err), 32'(clamp));
        if (!drop) chk("busy_after_pulse", 32'(busy), 32'(plen > 0));
    endtask

    task automatic wait_done(input string tag);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 10000) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_timeout"}, 32'(guard < 10000), 1);
        @(negedge clk);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_queue"}, 32'(exp_q.size()), 0);
`ifdef UDP_PAYLOAD_READER_STATS_EN
        chk({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pkt));
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_before;
        int len;
        rst_n = 1'b0;
        bus.udp_rec_data_valid  = 1'b0;
        bus.udp_rec_data_length = 16'd0;
        bus.udp_rec_ram_rdata   = 8'h00;
        fill_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_m_last", 32'(bus.m_last), 0);
        chk("rst_m_data", 32'(bus.m_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_len_err", 32'(len_err), 0);
        chk("rst_rd_en", 32'(bus.udp_rec_ram_read_en), 0);
        chk("rst_rd_addr", 32'(bus.udp_rec_ram_read_addr), 0);
`ifdef UDP_PAYLOAD_READER_STATS_EN
        chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: length 18, always ready, bytes 00..09, latency and throughput.
        ready_mode = 0;
        for (int i = 0; i < 10; i++) mem[i] = 8'(i);
        send(18);
        chk("t1_rd_en", 32'(bus.udp_rec_ram_read_en), 1);
        chk("t1_rd_addr", 32'(bus.udp_rec_ram_read_addr), 0);
        chk("t1_valid_early", 32'(bus.m_valid), 0);
        @(posedge clk);
        #1;
        chk("t1_first_valid", 32'(bus.m_valid), 1);
        for (int k = 1; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("t1_streaming", 32'(bus.m_valid), 1);
        end
        wait_done("t1");

        // 2: same packet under 1,0,0 back-pressure.
        ready_mode  = 1;
        ready_phase = 0;
        send(18);
        wait_done("t2");

        // 3: no-payload lengths.
        ready_mode = 0;
        rd_before  = rd_cnt;
        send(8);
        send(3);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_no_reads", 32'(rd_cnt - rd_before), 0);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_m_valid", 32'(bus.m_valid), 0);

        // 4: oversize packet clamped to RAM depth.
        fill_mem();
        send(2100);
        wait_done("t4");

        // 5a: second pulse mid-packet is dropped.
        fill_mem();
        send(40);
        repeat (5) @(posedge clk);
        #1;
        send(30);
        wait_done("t5a");

        // 5b: pulse in the cycle of the last handshake is dropped too.
        fill_mem();
        send(20);
        repeat (12) @(posedge clk);
        #1;
        send(30);
        chk("t5b_busy_after_late_pulse", 32'(busy), 0);
        wait_done("t5b");

        // 6: reset after 4 bytes of a 20-byte packet, then a clean packet.
        fill_mem();
        send(20);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_bytes_before_rst", 32'(12 - exp_q.size()), 4);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_m_valid", 32'(bus.m_valid), 0);
        chk("t6_rst_m_last", 32'(bus.m_last), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        exp_pkt  = 0;
        exp_drop = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(10);
        wait_done("t6");

        // Randomised packets, sink patterns and occasional extra pulses.
        repeat (25) begin
            ready_mode  = $urandom_range(0, 2);
            ready_phase = 0;
            fill_mem();
            len = $urandom_range(0, 70);
            send(len);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 8)) @(posedge clk);
                #1;
                send($urandom_range(9, 60));
            end
            wait_done("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
